// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - pipeline-to-hazard-unit signal bundle
//
// Carries the per-stage register addresses and write/load qualifiers, the
// long-latency issue/done handshakes, the redirect strobe, and the returned
// forwarding selects, stall/flush enables, busy vector and error flag.
//   master : pipeline side (drives stage info, consumes controls)
//   slave  : hazard_scoreboard (consumes stage info, drives controls)

interface hazard_scoreboard_if #(
   parameter int REG_AW   = 5,
   parameter int NUM_REGS = 32
);
   logic [REG_AW-1:0]   rs1_d, rs2_d, rd_d;
   logic                long_d, branch_d;
   logic [REG_AW-1:0]   rs1_e, rs2_e, rd_e;
   logic                reg_write_e, result_src_e;
   logic [REG_AW-1:0]   rd_m;
   logic                reg_write_m, result_src_m;
   logic [REG_AW-1:0]   rd_w;
   logic                reg_write_w;
   logic                issue_valid;
   logic [REG_AW-1:0]   issue_rd;
   logic                done_valid;
   logic [REG_AW-1:0]   done_rd;
   logic                redirect_e;
   logic [1:0]          forward_ae, forward_be;
   logic                forward_ad, forward_bd;
   logic                stall_f, stall_d, flush_d, flush_e;
   logic [NUM_REGS-1:0] busy_vec;
   logic                sb_err;

   modport master (
      output rs1_d, rs2_d, rd_d, long_d, branch_d,
      output rs1_e, rs2_e, rd_e, reg_write_e, result_src_e,
      output rd_m, reg_write_m, result_src_m, rd_w, reg_write_w,
      output issue_valid, issue_rd, done_valid, done_rd, redirect_e,
      input  forward_ae, forward_be, forward_ad, forward_bd,
      input  stall_f, stall_d, flush_d, flush_e, busy_vec, sb_err
   );

   modport slave (
      input  rs1_d, rs2_d, rd_d, long_d, branch_d,
      input  rs1_e, rs2_e, rd_e, reg_write_e, result_src_e,
      input  rd_m, reg_write_m, result_src_m, rd_w, reg_write_w,
      input  issue_valid, issue_rd, done_valid, done_rd, redirect_e,
      output forward_ae, forward_be, forward_ad, forward_bd,
      output stall_f, stall_d, flush_d, flush_e, busy_vec, sb_err
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RV32 5-stage hazard unit with long-latency busy scoreboard
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   hz              hazard_scoreboard_if.slave bundle (stage info in, controls out)
//   stall_cycles    (HAZARD_PERF_EN only) cycles with stall_d asserted, wraps
//   sb_stall_cycles (HAZARD_PERF_EN only) cycles stalled by the scoreboard
//                   while no redirect is pending, wraps
// Optional feature macro: HAZARD_PERF_EN

module hazard_scoreboard #(
   parameter int REG_AW          = 5,
   parameter int NUM_REGS        = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic               clk,
   input  logic               rst,
   hazard_scoreboard_if.slave hz
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]        stall_cycles,
   output logic [31:0]        sb_stall_cycles
`endif
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int POP_W = $clog2(NUM_REGS + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
   localparam logic [POP_W-1:0] MAX_POP = POP_W'(MAX_OUTSTANDING);

   logic [NUM_REGS-1:0] busy_q, busy_nxt, set_mask, clr_mask;
   logic [CNT_W-1:0]    count_q, count_nxt;
   logic [POP_W-1:0]    pop;
   logic                err_q;
   logic                count_full, issue_err, done_err;
   logic                lw_stall, br_stall, sb_stall, stall;
   logic                stall_d_int;

   // ---------------- scoreboard next state ----------------
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (hz.issue_valid && hz.issue_rd != '0)
         set_mask[hz.issue_rd] = 1'b1;
      if (hz.done_valid)
         clr_mask[hz.done_rd] = 1'b1;
      // set after clear: a new producer on the completing register stays busy
      busy_nxt    = (busy_q & ~clr_mask) | set_mask;
      busy_nxt[0] = 1'b0;
   end

   // Count is derived from the next busy vector rather than inc/dec so it can
   // never drift from the real population after illegal issues or completions;
   // it saturates at the outstanding limit.
   always_comb begin
      pop = '0;
      for (int i = 1; i < NUM_REGS; i++)
         pop = pop + POP_W'(busy_nxt[i]);
      if (pop >= MAX_POP)
         count_nxt = MAX_CNT;
      else
         count_nxt = pop[CNT_W-1:0];
   end

   assign count_full = (count_q == MAX_CNT);
   assign issue_err  = hz.issue_valid && (hz.issue_rd != '0) &&
                       (busy_q[hz.issue_rd] || count_full);
   assign done_err   = hz.done_valid &&
                       ((hz.done_rd == '0) || !busy_q[hz.done_rd]);

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         busy_q  <= busy_nxt;
         count_q <= count_nxt;
         if (issue_err || done_err)
            err_q <= 1'b1;
      end
   end

   // ---------------- forwarding ----------------
   always_comb begin
      hz.forward_ae = 2'b00;
      if (hz.rs1_e != '0 && hz.reg_write_m && hz.rd_m == hz.rs1_e)
         hz.forward_ae = 2'b10;
      else if (hz.rs1_e != '0 && hz.reg_write_w && hz.rd_w == hz.rs1_e)
         hz.forward_ae = 2'b01;

      hz.forward_be = 2'b00;
      if (hz.rs2_e != '0 && hz.reg_write_m && hz.rd_m == hz.rs2_e)
         hz.forward_be = 2'b10;
      else if (hz.rs2_e != '0 && hz.reg_write_w && hz.rd_w == hz.rs2_e)
         hz.forward_be = 2'b01;
   end

   assign hz.forward_ad = (hz.rs1_d != '0) && hz.reg_write_m && (hz.rd_m == hz.rs1_d);
   assign hz.forward_bd = (hz.rs2_d != '0) && hz.reg_write_m && (hz.rd_m == hz.rs2_d);

   // ---------------- stall detection ----------------
   assign lw_stall = hz.reg_write_e && hz.result_src_e && (hz.rd_e != '0) &&
                     ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

   // Branches compare in D, so an E-stage ALU result or an M-stage load
   // result is not yet available to the comparator.
   assign br_stall = hz.branch_d &&
                     ((hz.reg_write_e && (hz.rd_e != '0) &&
                       ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d))) ||
                      (hz.reg_write_m && hz.result_src_m && (hz.rd_m != '0) &&
                       ((hz.rd_m == hz.rs1_d) || (hz.rd_m == hz.rs2_d))));

   // RAW on a busy source, WAW on a busy destination, or no free slot.
   assign sb_stall = busy_q[hz.rs1_d] || busy_q[hz.rs2_d] ||
                     (hz.long_d && (hz.rd_d != '0) &&
                      (busy_q[hz.rd_d] || count_full));

   assign stall = lw_stall || br_stall || sb_stall;

   // ---------------- pipeline control ----------------
   always_comb begin
      if (hz.redirect_e) begin
         stall_d_int = 1'b0;
         hz.stall_f  = 1'b0;
         hz.flush_d  = 1'b1;
         hz.flush_e  = 1'b1;
      end else begin
         stall_d_int = stall;
         hz.stall_f  = stall;
         hz.flush_d  = 1'b0;
         hz.flush_e  = stall;
      end
   end

   assign hz.stall_d  = stall_d_int;
   assign hz.busy_vec = busy_q;
   assign hz.sb_err   = err_q;

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles    <= '0;
         sb_stall_cycles <= '0;
      end else begin
         if (stall_d_int)
            stall_cycles <= stall_cycles + 32'd1;
         if (sb_stall && !hz.redirect_e)
            sb_stall_cycles <= sb_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Next-generation hazard controller for the 5-stage RV32 pipeline; replaces the purely combinational hazard logic.
- Keeps E/D forwarding and load-use/branch stall detection, with load-use now gated on an actual register match.
- Adds a registered busy-bit scoreboard for variable-latency ops (mul/div, cache-miss loads) that complete out of band, with a bounded outstanding count, WAW protection and redirect priority.
- Sits beside the pipeline registers; drives their stall/flush enables and the forwarding muxes.

Parameters:
- REG_AW, 5, register address width.
- NUM_REGS, 32, architectural registers (2**REG_AW); x0 is never tracked.
- MAX_OUTSTANDING, 4, maximum simultaneously busy long-latency destinations (1..NUM_REGS-1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous active-high.
- rs1_d, rs2_d, rd_d  in  REG_AW  decode-stage source/dest addresses.
- long_d  in  1  decode instruction is long-latency.
- branch_d  in  1  decode instruction resolves a branch in D.
- rs1_e, rs2_e, rd_e  in  REG_AW  execute-stage addresses.
- reg_write_e, result_src_e  in  1  E writes rd; E is a load.
- rd_m  in  REG_AW; reg_write_m, result_src_m  in  1  memory-stage equivalents.
- rd_w  in  REG_AW; reg_write_w  in  1  writeback-stage equivalents.
- issue_valid  in  1; issue_rd  in  REG_AW  long-latency op leaves E this cycle.
- done_valid  in  1; done_rd  in  REG_AW  long-latency result written to regfile this cycle.
- redirect_e  in  1  taken branch/jump resolved in E.
- forward_ae, forward_be  out  2  00 regfile, 01 W, 10 M.
- forward_ad, forward_bd  out  1  M-to-D forward for branch compare.
- stall_f, stall_d, flush_d, flush_e  out  1  pipeline control.
- busy_vec  out  NUM_REGS  scoreboard state.
- sb_err  out  1  sticky protocol error.

Behaviour:
- Reset: synchronous, active-high; busy_vec=0, outstanding count=0, sb_err=0. Combinational outputs follow inputs with busy_vec=0.
- Forwarding (comb), identical rules for A/B:
  - src!=0 && reg_write_m && rd_m==src gives 10.
  - Else src!=0 && reg_write_w && rd_w==src gives 01.
  - Else 00. M has priority over W.
  - forward_ad/bd = rs!=0 && reg_write_m && rd_m==rs.
- lw_stall = reg_write_e && result_src_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
- br_stall = branch_d && ((reg_write_e && rd_e!=0 && rd_e matches rs1_d/rs2_d) || (reg_write_m && result_src_m && rd_m!=0 && rd_m matches rs1_d/rs2_d)).
- sb_stall = busy[rs1_d] || busy[rs2_d] || (long_d && rd_d!=0 && (busy[rd_d] || count==MAX_OUTSTANDING)).
- stall = lw_stall || br_stall || sb_stall.
- Outputs when redirect_e=0: stall_f=stall_d=flush_e=stall; flush_d=0.
- redirect_e=1 has priority: flush_d=1, flush_e=1, stall_f=stall_d=0.
- Scoreboard updates at clock edge:
  - issue_valid && issue_rd!=0 sets busy[issue_rd].
  - done_valid clears busy[done_rd].
  - Same register on same cycle: set wins (new producer).
  - Count tracks popcount(busy_vec); inc and dec on the same cycle leave it unchanged.
  - Busy is visible the cycle after issue. Stall releases the cycle after done; the regfile is write-first, so D reads the fresh value.
- sb_err set (sticky until rst) on any of:
  - done_valid to a non-busy register or x0.
  - issue_valid to an already-busy register.
  - issue_valid when count==MAX_OUTSTANDING.
- Illegal issues are still applied, with the counter saturating at MAX_OUTSTANDING.
- rst asserted mid-operation discards all pending entries; a late done_valid after reset sets sb_err.

Optional Feature:
- HAZARD_PERF_EN defined: adds outputs stall_cycles (32) and sb_stall_cycles (32).
  - Both reset to 0 and wrap modulo 2**32.
  - stall_cycles increments every cycle stall_d=1.
  - sb_stall_cycles increments when sb_stall=1 and redirect_e=0.
- Undefined: no counters, no extra ports, no extra flops.

Test Plan:
- Forward priority: rs1_e=5, reg_write_m=1, rd_m=5, reg_write_w=1, rd_w=5 -> forward_ae=10; with rd_m=6 -> 01; rs1_e=0 -> 00.
- Load-use: result_src_e=1, reg_write_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1; rs2_d=8 -> all 0 (no blanket load stall).
- Scoreboard: issue rd=9 at cycle n; rs1_d=9 -> stall from n+1 until done_rd=9 at cycle k; stall low at k+1; busy_vec[9] 0 at k+1.
- Capacity: issue rd=1..4 (MAX=4), then long_d=1, rd_d=10 -> stall; done rd=2 -> stall released next cycle.
- Redirect priority: redirect_e=1 with lw_stall active -> flush_d=1, flush_e=1, stall_f=0.
- Errors and reset: done_rd=12 not busy -> sb_err=1 next cycle; rst pulse -> busy_vec=0, sb_err=0; with HAZARD_PERF_EN, 3 stall cycles -> stall_cycles=3.
